fdiv_iter: RTL and testbench
============================

// Module: fdiv_iter
// PURPOSE
//  Multi-cycle IEEE-754 floating-point divider (op_a / op_b): radix-2 restoring mantissa division,
//  one quotient bit per clock, start/done handshake. Supplies the divide result and flags to
//  the alu op_code 2'b11 path, alongside the combinational fadd/fmul units. Shares their
//  format parameters, round_mode encoding and flag layout.
// PARAMETERS
//  exp    8                exponent field width
//  frac   23               fraction field width
//  width  exp+frac+1       total word width (derived; do not override)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request; sampled on a rising edge while busy=0
//  op_a        in   width  dividend; sampled with start
//  op_b        in   width  divisor; sampled with start
//  round_mode  in   1      0: round-nearest-even, 1: truncate toward zero; sampled with start
//  busy        out  1      high in DIV and ROUND states
//  done        out  1      one-cycle pulse; result/flags valid from this cycle
//  result      out  width  quotient; held until the next done
//  flags       out  5      [0] inexact [1] underflow [2] overflow [3] div_by_0 [4] invalid
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, flags=0. Reset mid-operation aborts; no done.
//  States: IDLE -> DIV -> ROUND -> DONE -> IDLE. A special case goes IDLE -> DONE.
//  DONE lasts one cycle. start is accepted in IDLE or DONE (back-to-back); ignored while busy=1.
//  Accept: latch sign=sa^sb and round_mode. Subnormal inputs are treated as signed zero (DAZ).
//  Specials, resolved at accept. done is high in the cycle after start (latency 1):
//   NaN input, 0/0, inf/inf -> canonical qNaN {0,all-ones,1,0..0}, flags=5'b10000
//   finite nonzero/0 -> signed inf, 5'b01000
//   inf/finite -> signed inf, 0
//   0/nonzero or finite/inf -> signed zero, 0
//  Normal path:
//   - exponent e=ea-eb+bias, signed, exp+2 bits.
//   - remainder=1.ma; divisor=1.mb.
//   - N=frac+3 DIV iterations, MSB first: remainder-divisor>=0 -> q bit 1, subtract; then shift left.
//   - Counter counts N-1..0; at 0 go to ROUND.
//  ROUND:
//   - if q MSB=0, shift q left 1 and decrement e.
//   - keep frac+1 bits, then guard bit; sticky = remaining q bit | (remainder!=0).
//   - RNE: increment on guard & (sticky | lsb); mantissa carry-out renormalises, e+1.
//   - inexact = guard | sticky.
//  Latency (normal): done high frac+5 cycles after the start cycle (28 at defaults).
//  Overflow (e>=2^exp-1 after rounding): RNE -> signed inf; truncate -> signed max finite.
//   flags overflow|inexact.
//  Underflow (e<=0 after rounding): flush to signed zero, flags underflow|inexact (no subnormal output).
//  result/flags update only on entry to DONE; done is registered, never combinational from start.
// CONFIGURATION
//  FDIV_ABORT_EN defined:
//   - adds input port abort (1 bit, after round_mode).
//   - abort=1 in DIV or ROUND returns to IDLE next edge: busy=0, no done, result/flags unchanged.
//   - abort takes priority over iteration; abort in IDLE or DONE has no effect.
//  Undefined: no abort port; every accepted operation runs to done.
// TESTING
//  1. 0x40C00000/0x40000000, rm=0 -> done at cycle +28, result 0x40400000, flags 5'b00000.
//  2. 0x3F800000/0x40400000 -> rm=0: 0x3EAAAAAB, 5'b00001; rm=1: 0x3EAAAAAA, 5'b00001.
//  3. 0x3F800000/0x00000000 -> 0x7F800000, 5'b01000, done at +1.
//     0x00000000/0x00000000 -> 0x7FC00000, 5'b10000, done at +1.
//  4. 0x7F000000/0x3E800000 -> rm=0: 0x7F800000, 5'b00101; rm=1: 0x7F7FFFFF, 5'b00101.
//     0x00800000/0x40000000 -> 0x00000000, 5'b00011.
//  5. Back-to-back: start in the done cycle -> second done exactly 28 cycles later.
//     start pulses while busy are ignored (results unchanged).
//  6. rst pulsed at cycle +10 of case 1 -> outputs 0, no done; new start completes normally.
//     With FDIV_ABORT_EN: abort at +10 -> busy=0 next cycle, no done.

Source files
------------

// File: rtl/fdiv_iter_if.sv
// Start/done handshake bundle for the iterative FP divider.
// The optional abort signal exists only when FDIV_ABORT_EN is defined.
interface fdiv_iter_if #(
    parameter int exp  = 8,
    parameter int frac = 23
);
    localparam int width = exp + frac + 1;

    logic             start;
    logic [width-1:0] op_a;
    logic [width-1:0] op_b;
    logic             round_mode;
`ifdef FDIV_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic [width-1:0] result;
    logic [4:0]       flags;

`ifdef FDIV_ABORT_EN
    modport master (
        output start, op_a, op_b, round_mode, abort,
        input  busy, done, result, flags
    );
    modport slave (
        input  start, op_a, op_b, round_mode, abort,
        output busy, done, result, flags
    );
`else
    modport master (
        output start, op_a, op_b, round_mode,
        input  busy, done, result, flags
    );
    modport slave (
        input  start, op_a, op_b, round_mode,
        output busy, done, result, flags
    );
`endif
endinterface

// File: rtl/fdiv_iter.sv
// Multi-cycle IEEE-754 divider, radix-2 restoring, one quotient bit per clock.
// Define FDIV_ABORT_EN to add an abort input that cancels a running divide.
module fdiv_iter #(
    parameter int exp  = 8,
    parameter int frac = 23
) (
    input  logic       clk,
    input  logic       rst,
    fdiv_iter_if.slave io
);
    localparam int width = exp + frac + 1;
    localparam int N     = frac + 3;
    localparam int CW    = $clog2(N);
    localparam int EW    = exp + 2;
    localparam int MW    = frac + 1;
    localparam int RW    = frac + 2;

    localparam logic [EW-1:0] BIAS = EW'((1 << (exp - 1)) - 1);
    localparam logic [EW-1:0] EMAX = EW'((1 << exp) - 1);

    localparam logic [width-1:0] QNAN =
        {1'b0, {exp{1'b1}}, 1'b1, {(frac-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_ROUND,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic            r_sign;
    logic            r_rm;
    logic [EW-1:0]   r_exp;
    logic [RW-1:0]   r_rem;
    logic [RW-1:0]   r_div;
    logic [N-1:0]    r_q;
    logic [CW-1:0]   r_cnt;
    logic [width-1:0] r_result;
    logic [4:0]      r_flags;

    logic [exp-1:0]  w_ea;
    logic [exp-1:0]  w_eb;
    logic [frac-1:0] w_fa;
    logic [frac-1:0] w_fb;
    logic w_a_zero, w_a_inf, w_a_nan;
    logic w_b_zero, w_b_inf, w_b_nan;
    logic w_sign;
    logic w_special;
    logic w_accept;
    logic w_abort;
    logic w_busy;

    logic [width-1:0] w_sp_res;
    logic [4:0]       w_sp_flg;

    logic [RW-1:0] w_sub;
    logic [RW-1:0] w_sel;
    logic [RW-1:0] w_rem_nxt;
    logic          w_qbit;

    logic [N-1:0]  w_norm;
    logic [EW-1:0] w_e1;
    logic [EW-1:0] w_e2;
    logic [MW-1:0] w_mant;
    logic [MW:0]   w_msum;
    logic [MW-1:0] w_mfin;
    logic w_guard, w_sticky, w_inc, w_inexact;
    logic w_ovf, w_unf;
    logic [width-1:0] w_rnd_res;
    logic [4:0]       w_rnd_flg;

    assign w_ea = io.op_a[width-2:frac];
    assign w_eb = io.op_b[width-2:frac];
    assign w_fa = io.op_a[frac-1:0];
    assign w_fb = io.op_b[frac-1:0];

    // Subnormals count as zero, so only the exponent field decides zero.
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (&w_ea) && (w_fa == '0);
    assign w_b_inf  = (&w_eb) && (w_fb == '0);
    assign w_a_nan  = (&w_ea) && (w_fa != '0);
    assign w_b_nan  = (&w_eb) && (w_fb != '0);

    assign w_sign    = io.op_a[width-1] ^ io.op_b[width-1];
    assign w_special = w_a_zero | w_b_zero | w_a_inf | w_b_inf |
                       w_a_nan | w_b_nan;

    assign w_busy   = (r_state == S_DIV) || (r_state == S_ROUND);
    assign w_accept = io.start &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef FDIV_ABORT_EN
    assign w_abort = io.abort && w_busy;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_sp_res = '0;
        w_sp_flg = '0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) ||
            (w_a_inf && w_b_inf)) begin
            w_sp_res = QNAN;
            w_sp_flg = 5'b10000;
        end else if (w_a_inf) begin
            w_sp_res = {w_sign, {exp{1'b1}}, {frac{1'b0}}};
        end else if (w_b_zero) begin
            w_sp_res = {w_sign, {exp{1'b1}}, {frac{1'b0}}};
            w_sp_flg = 5'b01000;
        end else begin
            w_sp_res = {w_sign, {(width-1){1'b0}}};
        end
    end

    assign w_qbit    = (r_rem >= r_div);
    assign w_sub     = r_rem - r_div;
    assign w_sel     = w_qbit ? w_sub : r_rem;
    assign w_rem_nxt = w_sel << 1;

    always_comb begin
        w_norm    = r_q[N-1] ? r_q : {r_q[N-2:0], 1'b0};
        w_e1      = r_q[N-1] ? r_exp : r_exp - EW'(1);
        w_mant    = w_norm[N-1 -: MW];
        w_guard   = w_norm[1];
        w_sticky  = w_norm[0] | (|r_rem);
        w_inc     = ~r_rm & w_guard & (w_sticky | w_mant[0]);
        w_msum    = {1'b0, w_mant} + {{MW{1'b0}}, w_inc};
        w_e2      = w_msum[MW] ? w_e1 + EW'(1) : w_e1;
        w_mfin    = w_msum[MW] ? w_msum[MW:1] : w_msum[MW-1:0];
        w_inexact = w_guard | w_sticky;
        w_ovf     = !w_e2[EW-1] && (w_e2 >= EMAX);
        w_unf     = w_e2[EW-1] || (w_e2 == '0);
        w_rnd_res = {r_sign, w_e2[exp-1:0], w_mfin[frac-1:0]};
        w_rnd_flg = {4'b0000, w_inexact};
        if (w_ovf) begin
            w_rnd_flg = 5'b00101;
            if (r_rm)
                w_rnd_res = {r_sign, {(exp-1){1'b1}}, 1'b0, {frac{1'b1}}};
            else
                w_rnd_res = {r_sign, {exp{1'b1}}, {frac{1'b0}}};
        end else if (w_unf) begin
            w_rnd_flg = 5'b00011;
            w_rnd_res = {r_sign, {(width-1){1'b0}}};
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)
                    w_next = w_special ? S_DONE : S_DIV;
                else
                    w_next = S_IDLE;
            end
            S_DIV: begin
                if (w_abort)
                    w_next = S_IDLE;
                else if (r_cnt == '0)
                    w_next = S_ROUND;
            end
            S_ROUND: begin
                w_next = w_abort ? S_IDLE : S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign   <= 1'b0;
            r_rm     <= 1'b0;
            r_exp    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_accept) begin
            r_sign <= w_sign;
            r_rm   <= io.round_mode;
            if (w_special) begin
                r_result <= w_sp_res;
                r_flags  <= w_sp_flg;
            end else begin
                r_exp <= {2'b00, w_ea} - {2'b00, w_eb} + BIAS;
                r_rem <= {1'b0, 1'b1, w_fa};
                r_div <= {1'b0, 1'b1, w_fb};
                r_q   <= '0;
                r_cnt <= CW'(N - 1);
            end
        end else if (r_state == S_DIV && !w_abort) begin
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[N-2:0], w_qbit};
            r_cnt <= r_cnt - CW'(1);
        end else if (r_state == S_ROUND && !w_abort) begin
            r_result <= w_rnd_res;
            r_flags  <= w_rnd_flg;
        end
    end

    assign io.busy   = w_busy;
    assign io.done   = (r_state == S_DONE);
    assign io.result = r_result;
    assign io.flags  = r_flags;
endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter: specials, rounding, overflow/underflow, handshake.
// Exercises the abort path too when FDIV_ABORT_EN is defined.
module tb_fdiv_iter;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;

    fdiv_iter_if io();
    fdiv_iter dut (.clk(clk), .rst(rst), .io(io));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic rm);
        io.start      = 1'b1;
        io.op_a       = a;
        io.op_b       = b;
        io.round_mode = rm;
    endtask

    task automatic finish_op(input string tag, input logic [31:0] er,
                             input logic [4:0] ef, input int el,
                             input bit noise);
        int lat;
        @(negedge clk);
        io.start = 1'b0;
        lat = 1;
        while (!io.done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (noise && lat == 5) launch(32'h3F800000, 32'h00000000, 1'b1);
            if (noise && lat == 6) io.start = 1'b0;
        end
        chk({tag, " lat"}, 32'(lat), 32'(el));
        chk({tag, " res"}, io.result, er);
        chk({tag, " flg"}, 32'(io.flags), 32'(ef));
    endtask

    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic rm,
                          input logic [31:0] er, input logic [4:0] ef,
                          input int el);
        @(negedge clk);
        launch(a, b, rm);
        finish_op(tag, er, ef, el, 1'b0);
    endtask

    task automatic expect_no_done(input string tag);
        int seen;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (io.done) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        io.start      = 1'b0;
        io.op_a       = '0;
        io.op_b       = '0;
        io.round_mode = 1'b0;
`ifdef FDIV_ABORT_EN
        io.abort      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(io.busy), 32'd0);
        chk("rst done", 32'(io.done), 32'd0);
        chk("rst res", io.result, 32'd0);
        chk("rst flg", 32'(io.flags), 32'd0);
        rst = 1'b0;

        run_op("6/2", 32'h40C00000, 32'h40000000, 1'b0,
               32'h40400000, 5'b00000, 28);
        @(negedge clk);
        chk("done pulse", 32'(io.done), 32'd0);
        chk("idle busy", 32'(io.busy), 32'd0);

        run_op("1/3 rne", 32'h3F800000, 32'h40400000, 1'b0,
               32'h3EAAAAAB, 5'b00001, 28);
        run_op("1/3 trz", 32'h3F800000, 32'h40400000, 1'b1,
               32'h3EAAAAAA, 5'b00001, 28);
        run_op("1/1", 32'h3F800000, 32'h3F800000, 1'b0,
               32'h3F800000, 5'b00000, 28);
        run_op("-6/2", 32'hC0C00000, 32'h40000000, 1'b0,
               32'hC0400000, 5'b00000, 28);

        run_op("1/0", 32'h3F800000, 32'h00000000, 1'b0,
               32'h7F800000, 5'b01000, 1);
        run_op("0/0", 32'h00000000, 32'h00000000, 1'b0,
               32'h7FC00000, 5'b10000, 1);
        run_op("nan", 32'h7FC00001, 32'h3F800000, 1'b0,
               32'h7FC00000, 5'b10000, 1);
        run_op("inf/2", 32'h7F800000, 32'h40000000, 1'b0,
               32'h7F800000, 5'b00000, 1);
        run_op("2/inf", 32'h40000000, 32'hFF800000, 1'b0,
               32'h80000000, 5'b00000, 1);
        run_op("daz a", 32'h00000001, 32'h3F800000, 1'b0,
               32'h00000000, 5'b00000, 1);
        run_op("daz b", 32'hBF800000, 32'h00000001, 1'b0,
               32'hFF800000, 5'b01000, 1);

        run_op("ovf rne", 32'h7F000000, 32'h3E800000, 1'b0,
               32'h7F800000, 5'b00101, 28);
        run_op("ovf trz", 32'h7F000000, 32'h3E800000, 1'b1,
               32'h7F7FFFFF, 5'b00101, 28);
        run_op("unf", 32'h00800000, 32'h40000000, 1'b0,
               32'h00000000, 5'b00011, 28);

        run_op("b2b a", 32'h40C00000, 32'h40000000, 1'b0,
               32'h40400000, 5'b00000, 28);
        launch(32'h3F800000, 32'h40400000, 1'b0);
        finish_op("b2b b", 32'h3EAAAAAB, 5'b00001, 28, 1'b1);

        @(negedge clk);
        launch(32'h40C00000, 32'h40000000, 1'b0);
        @(negedge clk);
        io.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid busy", 32'(io.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst busy", 32'(io.busy), 32'd0);
        chk("arst res", io.result, 32'd0);
        chk("arst flg", 32'(io.flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_no_done("arst nodone");
        run_op("after rst", 32'h40C00000, 32'h40000000, 1'b0,
               32'h40400000, 5'b00000, 28);

`ifdef FDIV_ABORT_EN
        @(negedge clk);
        launch(32'h3F800000, 32'h40400000, 1'b0);
        @(negedge clk);
        io.start = 1'b0;
        repeat (9) @(negedge clk);
        io.abort = 1'b1;
        @(negedge clk);
        io.abort = 1'b0;
        chk("abort busy", 32'(io.busy), 32'd0);
        chk("abort res", io.result, 32'h40400000);
        chk("abort flg", 32'(io.flags), 32'd0);
        expect_no_done("abort nodone");
        run_op("after abort", 32'h3F800000, 32'h40400000, 1'b1,
               32'h3EAAAAAA, 5'b00001, 28);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
